alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the alu.
- Accepts decoded instructions with a valid/ready handshake and resolves source operands by forwarding from the MEM and WB stages and the register-file read data.
- Presents registered a, b and ctrl to the alu.
- Holds up to two entries (skid buffer) so downstream backpressure never creates a combinational ready path back to decode.

Parameters:
XLEN, 32, operand/data width (matches alu a/b/out)
REG_AW, 5, register address width
CTRL_W, 4, alu ctrl width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept (registered)
in_rs1  in  REG_AW  source 1 address
in_rs2  in  REG_AW  source 2 address
in_rs1_data  in  XLEN  regfile read data 1
in_rs2_data  in  XLEN  regfile read data 2
in_imm  in  XLEN  sign-extended immediate
in_use_imm  in  1  b takes immediate instead of rs2
in_ctrl  in  CTRL_W  alu operation
in_rd  in  REG_AW  destination address
in_rd_we  in  1  destination write enable
mem_we  in  1  MEM stage writes a register
mem_rd  in  REG_AW  MEM destination
mem_data  in  XLEN  MEM result
wb_we  in  1  WB stage writes a register
wb_rd  in  REG_AW  WB destination
wb_data  in  XLEN  WB result
flush  in  1  discard all held entries
out_valid  out  1  head entry valid
out_ready  in  1  alu/EX consumer accepts
a  out  XLEN  alu operand a (head entry)
b  out  XLEN  alu operand b (head entry)
ctrl  out  CTRL_W  alu ctrl (head entry)
out_rd  out  REG_AW  head destination
out_rd_we  out  1  head write enable

Behaviour:
- Reset, and rst_n low mid-operation: state EMPTY, in_ready=1, out_valid=0, a/b/ctrl/out_rd=0, out_rd_we=0. Any in-flight entries are dropped.
- States and occupancy:
  - EMPTY (0 entries), ONE (head only), TWO (head + skid).
  - in_ready = (state != TWO). Driven from state only.
  - out_valid = (state != EMPTY).
- Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready.
- State transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> TWO; pop & !accept -> EMPTY; accept & pop -> ONE, with the new entry in head.
  - TWO: pop -> ONE, skid moves to head (no accept possible).
- Latency: an entry accepted at edge N is visible on a/b/ctrl after edge N, i.e. in cycle N+1.
- Operand resolution at capture, per source s (rs1, rs2):
  - s==0 -> 0.
  - else mem_we & mem_rd==s -> mem_data.
  - else wb_we & wb_rd==s -> wb_data.
  - else in_rsX_data.
  - MEM has priority over WB.
- b = in_imm when in_use_imm, else the resolved rs2. The entry stores rs1/rs2 addresses and use_imm for snooping.
- Snoop: each cycle an entry is held (not popped, not overwritten), if wb_we & wb_rd==stored src & src!=0, that operand updates to wb_data. Skipped for b when use_imm=1. Applies to head and skid independently.
- Flush: highest priority after reset. Next state EMPTY; the same-cycle accept is discarded; out_rd_we forced 0.
- flush & pop in the same cycle is legal; the consumer still takes the current head.
- Entries with in_rd_we=0 pass through unchanged; this stage does not interpret rd.

Optional Feature:
- Macro ALU_OPSTAGE_PERF_EN.
- Defined: adds output port stall_cnt (32 bits) and output fwd_cnt (32 bits).
  - stall_cnt increments each cycle with in_valid & !in_ready.
  - fwd_cnt increments once per accepted entry that used MEM or WB forwarding for any source.
  - Both reset to 0, saturate at all-ones, and are not cleared by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN/REG_AW/CTRL_W constants.
  - alu ctrl enum (4-bit).
  - opstage_entry_t struct {a, b, ctrl, rd, rd_we, rs1, rs2, use_imm}.
- One natural sub-module: operand_fwd_mux, the combinational forwarding select for one source, instantiated twice.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, a=b=0, ctrl=0.
- Basic: rs1=1 data 0x5, rs2=2 data 0x3, ctrl=ADD, out_ready=1 -> next cycle a=0x5, b=0x3, out_valid=1. The alu then yields 0x8.
- Forward priority: rs1=7, mem_we=1/mem_rd=7/mem_data=0xAAAA, wb_we=1/wb_rd=7/wb_data=0xBBBB -> a=0xAAAA. With rs1=0 under the same buses -> a=0.
- Backpressure: out_ready=0, two accepts -> state TWO, in_ready=0 next cycle, third in_valid held. out_ready=1 -> first then second entry emerge in order, none lost or duplicated.
- Snoop: head held with rs2=9 (use_imm=0), then wb_we=1/wb_rd=9/wb_data=0x1234 -> b=0x1234 the following cycle. With use_imm=1, imm 0x10 -> b stays 0x10.
- Flush: state TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_rd_we=0, flushed-cycle input not captured.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared types and constants for the ID/EX operand stage:
//                datapath widths, alu operation encoding, the held-entry
//                record, the stage occupancy states and the write-back
//                snoop helper applied to held entries.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN   = 32;   // operand/data width
    localparam int REG_AW = 5;    // register address width
    localparam int CTRL_W = 4;    // alu ctrl width

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    // One held instruction. Source addresses and use_imm are kept so the
    // operands can keep tracking write-back while the entry waits.
    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_imm;
    } opstage_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } opstage_state_e;

    // Refresh a waiting entry with the value WB is writing this cycle.
    // x0 is never tracked; an immediate b is never overwritten.
    function automatic opstage_entry_t snoop_entry(
        input opstage_entry_t    e,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_data
    );
        opstage_entry_t r;
        r = e;
        if (wb_we && (wb_rd != '0)) begin
            if (wb_rd == e.rs1) begin
                r.a = wb_data;
            end
            if (!e.use_imm && (wb_rd == e.rs2)) begin
                r.b = wb_data;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage_if
//  Description : Decode-side handshake, forwarding buses, flush and the
//                alu-side handshake of the ID/EX operand stage.
//                master : decode / pipeline control / EX consumer side
//                slave  : the operand stage itself
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_operand_stage_if;
    import rv_pkg::*;

    // decode side
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [XLEN-1:0]   in_rs1_data;
    logic [XLEN-1:0]   in_rs2_data;
    logic [XLEN-1:0]   in_imm;
    logic              in_use_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [REG_AW-1:0] in_rd;
    logic              in_rd_we;
    // forwarding sources
    logic              mem_we;
    logic [REG_AW-1:0] mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    // control
    logic              flush;
    // alu side
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] out_rd;
    logic              out_rd_we;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
               in_use_imm, in_ctrl, in_rd, in_rd_we,
               mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data,
               flush, out_ready,
        input  in_ready, out_valid, a, b, ctrl, out_rd, out_rd_we
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm,
               in_use_imm, in_ctrl, in_rd, in_rd_we,
               mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data,
               flush, out_ready,
        output in_ready, out_valid, a, b, ctrl, out_rd, out_rd_we
    );

endinterface
`default_nettype wire

// File: rtl/operand_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fwd_mux
//  Description : Combinational source-operand select for one source.
//                x0 reads as zero, then MEM result, then WB result, then
//                register-file data.
//  Ports       : i_src                 source register address
//                i_rf_data             register-file read data
//                i_mem_we/rd/data      MEM stage write
//                i_wb_we/rd/data       WB stage write
//                o_data                resolved operand
//                o_fwd                 operand came from MEM or WB
//  Revision    : 1.0  initial release
// ============================================================================
module operand_fwd_mux
    import rv_pkg::*;
(
    input  logic [REG_AW-1:0] i_src,
    input  logic [XLEN-1:0]   i_rf_data,
    input  logic              i_mem_we,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic [XLEN-1:0]   i_mem_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic [XLEN-1:0]   o_data,
    output logic              o_fwd
);

    always_comb begin
        o_data = i_rf_data;
        o_fwd  = 1'b0;
        if (i_src == '0) begin
            o_data = '0;
        end else if (i_mem_we && (i_mem_rd == i_src)) begin
            // MEM is the younger producer, so it wins over WB
            o_data = i_mem_data;
            o_fwd  = 1'b1;
        end else if (i_wb_we && (i_wb_rd == i_src)) begin
            o_data = i_wb_data;
            o_fwd  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : ID/EX stage in front of the alu. Resolves operands with
//                MEM/WB forwarding at capture, holds up to two entries
//                (head + skid) so in_ready is a pure register, keeps held
//                operands current by snooping WB, presents the head entry
//                as registered a/b/ctrl.
//  Ports       : clk                  rising-edge clock
//                rst_n                synchronous active-low reset
//                bus (slave)          decode handshake, forwarding buses,
//                                     flush, alu handshake and outputs
//                stall_cnt, fwd_cnt   performance counters, only when
//                                     ALU_OPSTAGE_PERF_EN is defined
//  Revision    : 1.0  initial release
// ============================================================================
module alu_operand_stage
    import rv_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
`ifdef ALU_OPSTAGE_PERF_EN
    output logic [31:0]         stall_cnt,
    output logic [31:0]         fwd_cnt,
`endif
    alu_operand_stage_if.slave  bus
);

    opstage_state_e  r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    opstage_entry_t  r_head;
    opstage_entry_t  r_skid;

    logic            w_accept;
    logic            w_pop;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_fwd_rs1;
    logic            w_fwd_rs2;
    opstage_entry_t  w_new;
    opstage_entry_t  w_head_snp;
    opstage_entry_t  w_skid_snp;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_pop    = r_out_valid & bus.out_ready;

    operand_fwd_mux u_fwd_rs1 (
        .i_src      (bus.in_rs1),
        .i_rf_data  (bus.in_rs1_data),
        .i_mem_we   (bus.mem_we),
        .i_mem_rd   (bus.mem_rd),
        .i_mem_data (bus.mem_data),
        .i_wb_we    (bus.wb_we),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_data),
        .o_data     (w_rs1_val),
        .o_fwd      (w_fwd_rs1)
    );

    operand_fwd_mux u_fwd_rs2 (
        .i_src      (bus.in_rs2),
        .i_rf_data  (bus.in_rs2_data),
        .i_mem_we   (bus.mem_we),
        .i_mem_rd   (bus.mem_rd),
        .i_mem_data (bus.mem_data),
        .i_wb_we    (bus.wb_we),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_data  (bus.wb_data),
        .o_data     (w_rs2_val),
        .o_fwd      (w_fwd_rs2)
    );

    always_comb begin
        w_new         = '0;
        w_new.a       = w_rs1_val;
        w_new.b       = bus.in_use_imm ? bus.in_imm : w_rs2_val;
        w_new.ctrl    = bus.in_ctrl;
        w_new.rd      = bus.in_rd;
        w_new.rd_we   = bus.in_rd_we;
        w_new.rs1     = bus.in_rs1;
        w_new.rs2     = bus.in_rs2;
        w_new.use_imm = bus.in_use_imm;
    end

    // Snooped copies are what a held entry becomes at the next edge; the
    // skid copy is also what moves into the head when the head is popped.
    assign w_head_snp = snoop_entry(r_head, bus.wb_we, bus.wb_rd, bus.wb_data);
    assign w_skid_snp = snoop_entry(r_skid, bus.wb_we, bus.wb_rd, bus.wb_data);

    // Occupancy FSM. in_ready/out_valid are registered alongside the state
    // so neither depends combinationally on out_ready. Flush clears the
    // entries too, which forces out_rd_we low.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head      <= '0;
            r_skid      <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_head      <= w_new;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_pop) begin
                        r_head     <= w_head_snp;
                        r_skid     <= w_new;
                        r_state    <= ST_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_accept && w_pop) begin
                        r_head <= w_new;
                    end else if (w_pop) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_head <= w_head_snp;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_head     <= w_skid_snp;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_head <= w_head_snp;
                        r_skid <= w_skid_snp;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_head      <= '0;
                    r_skid      <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.a         = r_head.a;
    assign bus.b         = r_head.b;
    assign bus.ctrl      = r_head.ctrl;
    assign bus.out_rd    = r_head.rd;
    assign bus.out_rd_we = r_head.rd_we;

`ifdef ALU_OPSTAGE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;
    logic        w_used_fwd;

    // An immediate b does not count as forwarded even if rs2 matched.
    assign w_used_fwd = w_fwd_rs1 | (w_fwd_rs2 & ~bus.in_use_imm);

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (bus.in_valid && !r_in_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_accept && w_used_fwd && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = w_fwd_rs1 | w_fwd_rs2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_stage
//  Description : Self-checking bench for alu_operand_stage: a directed
//                table of {inputs, expected outputs} rows, then randomized
//                traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;
    import rv_pkg::*;

    logic clk;
    logic rst_n;

    alu_operand_stage_if u_if ();

`ifdef ALU_OPSTAGE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    alu_operand_stage u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ALU_OPSTAGE_PERF_EN
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt),
`endif
        .bus       (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        // stimulus
        logic        rst_n, in_valid, use_imm, rd_we, mem_we, wb_we, flush, out_ready;
        logic [4:0]  rs1, rs2, rd, mem_rd, wb_rd;
        logic [31:0] rs1_data, rs2_data, imm, mem_data, wb_data;
        logic [3:0]  ctrl;
        // expectation after the next clock edge
        logic        e_valid, e_ready, chk_data, chk_we, e_rd_we;
        logic [31:0] e_a, e_b;
        logic [3:0]  e_ctrl;
        logic [4:0]  e_rd;
    } vec_t;

    typedef struct {
        logic [31:0] a, b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
        logic [4:0]  rs1, rs2;
        logic        ui;
    } ment_t;

    localparam int NV = 20;
    vec_t  tbl [NV];
    vec_t  rv;
    ment_t mq [$];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic vec_t idle();
        vec_t v;
        v = '{default: '0};
        v.rst_n     = 1'b1;
        v.out_ready = 1'b1;
        return v;
    endfunction

    function automatic vec_t vin(logic iv, logic [4:0] s1, logic [31:0] d1,
                                 logic [4:0] s2, logic [31:0] d2,
                                 logic [3:0] c, logic [4:0] d, logic ordy);
        vec_t v;
        v = idle();
        v.in_valid = iv; v.rs1 = s1; v.rs1_data = d1; v.rs2 = s2; v.rs2_data = d2;
        v.ctrl = c; v.rd = d; v.rd_we = 1'b1; v.out_ready = ordy;
        return v;
    endfunction

    function automatic vec_t ex(vec_t vi, logic vld, logic rdy, logic [31:0] ea,
                                logic [31:0] eb, logic [3:0] ec, logic [4:0] erd,
                                logic cd, logic cw, logic we);
        vec_t v;
        v = vi;
        v.e_valid = vld; v.e_ready = rdy; v.e_a = ea; v.e_b = eb; v.e_ctrl = ec;
        v.e_rd = erd; v.chk_data = cd; v.chk_we = cw; v.e_rd_we = we;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_n             = v.rst_n;
        u_if.in_valid     = v.in_valid;
        u_if.in_rs1       = v.rs1;
        u_if.in_rs2       = v.rs2;
        u_if.in_rs1_data  = v.rs1_data;
        u_if.in_rs2_data  = v.rs2_data;
        u_if.in_imm       = v.imm;
        u_if.in_use_imm   = v.use_imm;
        u_if.in_ctrl      = v.ctrl;
        u_if.in_rd        = v.rd;
        u_if.in_rd_we     = v.rd_we;
        u_if.mem_we       = v.mem_we;
        u_if.mem_rd       = v.mem_rd;
        u_if.mem_data     = v.mem_data;
        u_if.wb_we        = v.wb_we;
        u_if.wb_rd        = v.wb_rd;
        u_if.wb_data      = v.wb_data;
        u_if.flush        = v.flush;
        u_if.out_ready    = v.out_ready;
    endtask

    task automatic check_row(input string nm, input int idx, input vec_t v);
        logic ok;
        ok = (u_if.out_valid === v.e_valid) && (u_if.in_ready === v.e_ready);
        if (v.chk_data) begin
            ok = ok && (u_if.a === v.e_a) && (u_if.b === v.e_b) &&
                 (u_if.ctrl === v.e_ctrl) && (u_if.out_rd === v.e_rd);
        end
        if (v.chk_we) begin
            ok = ok && (u_if.out_rd_we === v.e_rd_we);
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s %0d: got vld=%b rdy=%b a=%h b=%h ctrl=%h rd=%h we=%b ; want vld=%b rdy=%b a=%h b=%h ctrl=%h rd=%h we=%b (data chk=%b we chk=%b)",
                     nm, idx, u_if.out_valid, u_if.in_ready, u_if.a, u_if.b, u_if.ctrl,
                     u_if.out_rd, u_if.out_rd_we, v.e_valid, v.e_ready, v.e_a, v.e_b,
                     v.e_ctrl, v.e_rd, v.e_rd_we, v.chk_data, v.chk_we);
        end
    endtask

    // Operand value the instruction should see, straight from the rules.
    function automatic logic [31:0] resolve(vec_t v, logic [4:0] s, logic [31:0] rf);
        if (s == 5'd0)                      return 32'd0;
        if (v.mem_we && (v.mem_rd == s))    return v.mem_data;
        if (v.wb_we && (v.wb_rd == s))      return v.wb_data;
        return rf;
    endfunction

    // Reference model: a FIFO of at most two entries, advanced once per
    // clock edge with the inputs about to be sampled; fills in expectations.
    task automatic model_step(inout vec_t v);
        logic  acc;
        logic  pop;
        ment_t m;
        if (!v.rst_n || v.flush) begin
            mq.delete();
        end else begin
            acc = v.in_valid && (mq.size() < 2);
            pop = (mq.size() > 0) && v.out_ready;
            if (pop) void'(mq.pop_front());
            for (int k = 0; k < mq.size(); k++) begin
                if (v.wb_we && (v.wb_rd != 5'd0)) begin
                    if (mq[k].rs1 == v.wb_rd) mq[k].a = v.wb_data;
                    if (!mq[k].ui && (mq[k].rs2 == v.wb_rd)) mq[k].b = v.wb_data;
                end
            end
            if (acc) begin
                m.a    = resolve(v, v.rs1, v.rs1_data);
                m.b    = v.use_imm ? v.imm : resolve(v, v.rs2, v.rs2_data);
                m.ctrl = v.ctrl; m.rd = v.rd; m.we = v.rd_we;
                m.rs1  = v.rs1;  m.rs2 = v.rs2; m.ui = v.use_imm;
                mq.push_back(m);
            end
        end
        v.e_valid  = (mq.size() > 0);
        v.e_ready  = (mq.size() < 2);
        v.chk_data = (mq.size() > 0);
        v.chk_we   = (mq.size() > 0);
        if (mq.size() > 0) begin
            v.e_a = mq[0].a; v.e_b = mq[0].b; v.e_ctrl = mq[0].ctrl;
            v.e_rd = mq[0].rd; v.e_rd_we = mq[0].we;
        end
    endtask

    initial begin
        vec_t v;

        // ---------------- directed table ----------------
        v = vin(1, 1, 32'h5, 2, 32'h3, ALU_ADD, 3, 1); v.rst_n = 1'b0;
        tbl[0]  = ex(v, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        tbl[1]  = tbl[0];
        tbl[2]  = ex(vin(1, 1, 32'h5, 2, 32'h3, ALU_ADD, 3, 1), 1, 1, 32'h5, 32'h3, ALU_ADD, 3, 1, 1, 1);
        v = vin(1, 7, 32'h1111, 0, 32'h2222, ALU_SUB, 4, 1);
        v.mem_we = 1; v.mem_rd = 7; v.mem_data = 32'hAAAA; v.wb_we = 1; v.wb_rd = 7; v.wb_data = 32'hBBBB;
        tbl[3]  = ex(v, 1, 1, 32'hAAAA, 32'h0, ALU_SUB, 4, 1, 1, 1);
        v.rs1 = 0; v.rs2 = 7; v.rs2_data = 32'h3333; v.ctrl = ALU_AND; v.rd = 5;
        tbl[4]  = ex(v, 1, 1, 32'h0, 32'hAAAA, ALU_AND, 5, 1, 1, 1);
        v = vin(1, 8, 32'h1111, 9, 32'h3333, ALU_OR, 6, 1);
        v.wb_we = 1; v.wb_rd = 8; v.wb_data = 32'hCCCC; v.mem_we = 1; v.mem_rd = 9; v.mem_data = 32'hDDDD;
        tbl[5]  = ex(v, 1, 1, 32'hCCCC, 32'hDDDD, ALU_OR, 6, 1, 1, 1);
        tbl[6]  = ex(vin(1, 1, 32'h10, 2, 32'h20, ALU_XOR, 7, 0), 1, 0, 32'hCCCC, 32'hDDDD, ALU_OR, 6, 1, 1, 1);
        tbl[7]  = ex(vin(1, 1, 32'h99, 0, 0, ALU_SLL, 8, 0), 1, 0, 32'hCCCC, 32'hDDDD, ALU_OR, 6, 1, 1, 1);
        tbl[8]  = ex(vin(1, 1, 32'h99, 0, 0, ALU_SLL, 8, 1), 1, 1, 32'h10, 32'h20, ALU_XOR, 7, 1, 1, 1);
        tbl[9]  = ex(vin(1, 1, 32'h99, 0, 0, ALU_SLL, 8, 1), 1, 1, 32'h99, 32'h0, ALU_SLL, 8, 1, 1, 1);
        tbl[10] = ex(vin(0, 0, 0, 0, 0, 0, 0, 1), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = ex(vin(1, 0, 0, 9, 32'h5555, ALU_SRL, 9, 0), 1, 1, 32'h0, 32'h5555, ALU_SRL, 9, 1, 1, 1);
        v = vin(0, 0, 0, 0, 0, 0, 0, 0); v.wb_we = 1; v.wb_rd = 9; v.wb_data = 32'h1234;
        tbl[12] = ex(v, 1, 1, 32'h0, 32'h1234, ALU_SRL, 9, 1, 1, 1);
        v = vin(1, 0, 0, 9, 32'h7777, ALU_SRA, 10, 1); v.use_imm = 1; v.imm = 32'h10;
        tbl[13] = ex(v, 1, 1, 32'h0, 32'h10, ALU_SRA, 10, 1, 1, 1);
        v = vin(0, 0, 0, 0, 0, 0, 0, 0); v.wb_we = 1; v.wb_rd = 9; v.wb_data = 32'h1234;
        tbl[14] = ex(v, 1, 1, 32'h0, 32'h10, ALU_SRA, 10, 1, 1, 1);
        tbl[15] = ex(vin(1, 1, 32'h41, 0, 0, ALU_SLT, 11, 0), 1, 0, 32'h0, 32'h10, ALU_SRA, 10, 1, 1, 1);
        v = vin(1, 1, 32'h42, 0, 0, ALU_SLTU, 12, 0); v.flush = 1;
        tbl[16] = ex(v, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[17] = ex(vin(0, 0, 0, 0, 0, 0, 0, 1), 0, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[18] = ex(vin(1, 1, 32'h50, 0, 0, ALU_ADD, 13, 0), 1, 1, 32'h50, 32'h0, ALU_ADD, 13, 1, 1, 1);
        v = vin(0, 0, 0, 0, 0, 0, 0, 1); v.flush = 1;
        tbl[19] = ex(v, 0, 1, 0, 0, 0, 0, 0, 1, 0);

        drive(idle());
        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check_row("row", i, tbl[i]);
        end

        // ---------------- randomized against model ----------------
        for (int i = 0; i < 2; i++) begin
            rv = idle(); rv.rst_n = 1'b0;
            drive(rv);
            model_step(rv);
            @(negedge clk);
        end
        for (int i = 0; i < 3000; i++) begin
            rv = idle();
            rv.rst_n     = ($urandom_range(99) != 0);
            rv.flush     = ($urandom_range(31) == 0);
            rv.in_valid  = ($urandom_range(9) < 7);
            rv.out_ready = ($urandom_range(9) < 6);
            rv.rs1       = 5'($urandom_range(3));
            rv.rs2       = 5'($urandom_range(3));
            rv.rs1_data  = $urandom;
            rv.rs2_data  = $urandom;
            rv.imm       = $urandom;
            rv.use_imm   = ($urandom_range(2) == 0);
            rv.ctrl      = 4'($urandom);
            rv.rd        = 5'($urandom);
            rv.rd_we     = 1'($urandom);
            rv.mem_we    = 1'($urandom);
            rv.mem_rd    = 5'($urandom_range(3));
            rv.mem_data  = $urandom;
            rv.wb_we     = 1'($urandom);
            rv.wb_rd     = 5'($urandom_range(3));
            rv.wb_data   = $urandom;
            drive(rv);
            model_step(rv);
            @(negedge clk);
            check_row("rand", i, rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
